// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bundle for the pipelined ALU/accumulator.
// The opcode is the concatenation {m, s1, s0}; m=1 selects the logic unit.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,  // A + B + cin
    OP_SUB = 3'b001,  // A + ~B + cin
    OP_INC = 3'b010,  // A + cin
    OP_DEC = 3'b011,  // A + all-ones + cin
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic cout;
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;

  function automatic alu_op_e pack_op(input logic m, input logic s1, input logic s0);
    return alu_op_e'({m, s1, s0});
  endfunction

endpackage

// File: rtl/alu_pipe_acc_if.sv
// Handshake/operand bundle for alu_pipe_acc; the master side offers operations
// and consumes results, the slave side is the ALU pipeline.
interface alu_pipe_acc_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             s1;
  logic             s0;
  logic             m;
  logic             acc_sel;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             cout;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, s1, s0, m, acc_sel, acc_clr, out_ready,
    input  in_ready, out_valid, f, cout, zero, neg, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, s1, s0, m, acc_sel, acc_clr, out_ready,
    output in_ready, out_valid, f, cout, zero, neg, ovf
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational WIDTH-bit ALU: one shared adder for the arithmetic
// group, bitwise unit for the logic group.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] w_b_mux;
  logic [WIDTH:0]   w_sum;

  // Every arithmetic op is A + operand + cin; only the second operand changes.
  always_comb begin
    // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
    w_b_mux = b;
    case (op)
      OP_SUB:  w_b_mux = ~b;
      OP_INC:  w_b_mux = '0;
      OP_DEC:  w_b_mux = '1;
      default: w_b_mux = b;
    endcase
  end

  assign w_sum = {1'b0, a} + {1'b0, w_b_mux} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    f    = '0;
    cout = 1'b0;
    ovf  = 1'b0;
    case (op)
      OP_AND: f = a & b;
      OP_OR:  f = a | b;
      OP_XOR: f = a ^ b;
      OP_NOT: f = ~a;
      default: begin
        f    = w_sum[WIDTH-1:0];
        cout = w_sum[WIDTH];
        // Signed overflow: operands agree in sign but the result does not.
        ovf  = (a[WIDTH-1] == w_b_mux[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe_acc.sv
// Two-stage valid/ready ALU pipeline with an accumulator that can replace
// operand A; stage 1 holds the accepted op, stage 2 holds the result.
module alu_pipe_acc
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             s1,
  input  logic             s0,
  input  logic             m,
  input  logic             acc_sel,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  // Stage 1: accepted operation
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_cin;
  alu_op_e          r_s1_op;
  logic             r_s1_acc_sel;

  // Stage 2: registered result
  logic             r_out_valid;
  logic [WIDTH-1:0] r_f;
  alu_flags_t       r_flags;
  logic [WIDTH-1:0] r_acc;

  logic             w_accept;
  logic             w_s2_load;
  logic [WIDTH-1:0] w_core_a;
  logic [WIDTH-1:0] w_core_f;
  logic             w_core_cout;
  logic             w_core_ovf;
  alu_flags_t       w_flags;

  assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready  = !rst && (!r_s1_valid || w_s2_load);
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // NOTE: payload registers are qualified by r_s1_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_a       <= a;
      r_s1_b       <= b;
      r_s1_cin     <= cin;
      r_s1_op      <= pack_op(m, s1, s0);
      r_s1_acc_sel <= acc_sel;
    end
  end

  // A is chosen at stage-2 load so back-to-back accumulate ops see the newest result.
  assign w_core_a = r_s1_acc_sel ? r_acc : r_s1_a;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a    (w_core_a),
    .b    (r_s1_b),
    .cin  (r_s1_cin),
    .op   (r_s1_op),
    .f    (w_core_f),
    .cout (w_core_cout),
    .ovf  (w_core_ovf)
  );

  assign w_flags = '{
    cout: w_core_cout,
    zero: (w_core_f == '0),
    neg:  w_core_f[WIDTH-1],
    ovf:  w_core_ovf
  };

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_f         <= '0;
      r_flags     <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= 1'b1;
      r_f         <= w_core_f;
      r_flags     <= w_flags;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // A clear request overrides the result write-back in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || acc_clr) begin
      r_acc <= '0;
    end else if (w_s2_load) begin
      r_acc <= w_core_f;
    end
  end

  assign out_valid = r_out_valid;
  assign f         = r_f;
  assign cout      = r_flags.cout;
  assign zero      = r_flags.zero;
  assign neg       = r_flags.neg;
  assign ovf       = r_flags.ovf;

endmodule

// File: tb/tb_alu_pipe_acc.sv
// Directed bench for alu_pipe_acc (WIDTH=4): a scoreboard models every accepted
// op and compares it when the result is consumed; directed steps probe timing.
module tb_alu_pipe_acc;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] f;
    logic         cout;
    logic         zero;
    logic         neg;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [W-1:0] model_acc;

  alu_pipe_acc_if #(.WIDTH(W)) bus ();

  alu_pipe_acc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .a         (bus.a),
    .b         (bus.b),
    .cin       (bus.cin),
    .s1        (bus.s1),
    .s0        (bus.s0),
    .m         (bus.m),
    .acc_sel   (bus.acc_sel),
    .acc_clr   (bus.acc_clr),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .f         (bus.f),
    .cout      (bus.cout),
    .zero      (bus.zero),
    .neg       (bus.neg),
    .ovf       (bus.ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model written with integer arithmetic rather than bit tricks.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic c, input logic mm, input logic [1:0] s);
    exp_t e;
    int ua, ub, full, sa, sb2, ss;
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    if (mm) begin
      case (s)
        2'b00:   e.f = av & bv;
        2'b01:   e.f = av | bv;
        2'b10:   e.f = av ^ bv;
        default: e.f = ~av;
      endcase
    end else begin
      ua = int'(av);
      case (s)
        2'b00:   ub = int'(bv);
        2'b01:   ub = 15 - int'(bv);
        2'b10:   ub = 0;
        default: ub = 15;
      endcase
      full   = ua + ub + int'(c);
      e.f    = W'(full);
      e.cout = (full > 15);
      sa     = (ua > 7) ? ua - 16 : ua;
      sb2    = (ub > 7) ? ub - 16 : ub;
      ss     = sa + sb2 + int'(c);
      e.ovf  = (ss > 7) || (ss < -8);
    end
    e.zero = (e.f == '0);
    e.neg  = e.f[W-1];
    return e;
  endfunction

  // Scoreboard: push on accept, pop on consume.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      model_acc = '0;
    end else begin
      if (bus.acc_clr) model_acc = '0;
      if (bus.out_valid && bus.out_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_result", {bus.f, bus.cout, bus.zero, bus.neg, bus.ovf},
                {e.f, e.cout, e.zero, e.neg, e.ovf});
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.acc_sel ? model_acc : bus.a, bus.b, bus.cin, bus.m, {bus.s1, bus.s0});
        sb.push_back(e);
        model_acc = e.f;
      end
    end
  end

  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c,
                       input logic mm, input logic [1:0] s, input logic asel);
    bus.a       = av;
    bus.b       = bv;
    bus.cin     = c;
    bus.m       = mm;
    bus.s1      = s[1];
    bus.s0      = s[0];
    bus.acc_sel = asel;
  endtask

  // Offers one op and returns 1 ns after the edge that accepted it.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c,
                      input logic mm, input logic [1:0] s, input logic asel);
    logic took;
    took = 1'b0;
    drive(av, bv, c, mm, s, asel);
    bus.in_valid = 1'b1;
    for (int t = 0; t < 50 && !took; t++) begin
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!took) check("send_timeout", 32'(took), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bus.out_valid || sb.size() != 0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic [W-1:0] bp_a[3];
    logic [W-1:0] bp_b[3];
    logic [1:0]   bp_s[3];
    logic         bp_m[3];

    checks       = 0;
    errors       = 0;
    model_acc    = '0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b0;
    bus.out_ready = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_f", 32'(bus.f), 32'd0);
    check("rst_flags", {bus.cout, bus.zero, bus.neg, bus.ovf}, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Add with signed overflow; result visible one edge after the accept edge.
    send(4'h7, 4'h1, 1'b0, 1'b0, 2'b00, 1'b0);
    check("add_not_yet", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("add_valid", 32'(bus.out_valid), 32'd1);
    check("add_f", 32'(bus.f), 32'h8);
    check("add_flags", {bus.cout, bus.zero, bus.neg, bus.ovf}, 32'b0011);
    @(posedge clk);
    #1;
    check("add_consumed", 32'(bus.out_valid), 32'd0);

    // Subtract, back to back.
    send(4'h3, 4'h5, 1'b1, 1'b0, 2'b01, 1'b0);
    send(4'h5, 4'h5, 1'b1, 1'b0, 2'b01, 1'b0);
    check("sub_f", 32'(bus.f), 32'hE);
    check("sub_flags", {bus.cout, bus.zero, bus.neg, bus.ovf}, 32'b0010);
    @(posedge clk);
    #1;
    check("sub_eq_f", 32'(bus.f), 32'h0);
    check("sub_eq_flags", {bus.cout, bus.zero, bus.neg, bus.ovf}, 32'b1100);

    // Logic unit: XOR and NOT.
    send(4'hA, 4'hF, 1'b1, 1'b1, 2'b10, 1'b0);
    send(4'hA, 4'hF, 1'b1, 1'b1, 2'b11, 1'b0);
    check("xor_f", 32'(bus.f), 32'h5);
    check("xor_cout_ovf", {bus.cout, bus.ovf}, 32'b00);
    @(posedge clk);
    #1;
    check("not_f", 32'(bus.f), 32'h5);
    drain();

    // Backpressure: three ops offered while the consumer stalls.
    bp_a = '{4'h1, 4'h4, 4'h9};
    bp_b = '{4'h2, 4'h4, 4'h3};
    bp_s = '{2'b00, 2'b00, 2'b00};
    bp_m = '{1'b0, 1'b0, 1'b1};
    bus.out_ready = 1'b0;
    idx = 0;
    for (int t = 0; t < 4; t++) begin
      drive(bp_a[idx], bp_b[idx], 1'b0, bp_m[idx], bp_s[idx], 1'b0);
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.in_ready) idx++;
      @(posedge clk);
      #1;
    end
    check("bp_accepted", 32'(idx), 32'd2);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    for (int t = 0; t < 3; t++) begin
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_f", 32'(bus.f), 32'h3);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(bp_a[2], bp_b[2], 1'b0, bp_m[2], bp_s[2], 1'b0);
    drain();

    // Accumulate: clear, then four chained acc_sel adds of 3.
    bus.acc_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.acc_clr = 1'b0;
    send(4'hF, 4'h3, 1'b0, 1'b0, 2'b00, 1'b1);
    send(4'hF, 4'h3, 1'b0, 1'b0, 2'b00, 1'b1);
    check("acc_1", {bus.out_valid, bus.f}, 32'h13);
    send(4'hF, 4'h3, 1'b0, 1'b0, 2'b00, 1'b1);
    check("acc_2", {bus.out_valid, bus.f}, 32'h16);
    send(4'hF, 4'h3, 1'b0, 1'b0, 2'b00, 1'b1);
    check("acc_3", {bus.out_valid, bus.f}, 32'h19);
    @(posedge clk);
    #1;
    check("acc_4", {bus.out_valid, bus.f}, 32'h1C);
    drain();

    // Reset with two ops in flight.
    bus.out_ready = 1'b0;
    send(4'h1, 4'h1, 1'b0, 1'b0, 2'b00, 1'b0);
    send(4'h2, 4'h2, 1'b0, 1'b0, 2'b00, 1'b0);
    rst = 1'b1;
    drive(4'h6, 4'h1, 1'b0, 1'b0, 2'b00, 1'b0);
    bus.in_valid = 1'b1;
    #1;
    check("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_f", 32'(bus.f), 32'd0);
    check("rst_mid_in_ready2", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_no_accept", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", 32'(bus.out_valid), 32'd0);
    send(4'h9, 4'h1, 1'b0, 1'b0, 2'b00, 1'b1);
    @(posedge clk);
    #1;
    check("post_rst_acc", 32'(bus.f), 32'h1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
